mux8_1: RTL and testbench
=========================

Name: mux8_1

Overview:
- Registered 8-to-1 multiplexer: selects one of eight input lanes by a 3-bit select and presents it on a registered output.
- Used as a generic lane selector wherever a single bit (or narrow field) must be picked from an 8-lane bus on a clean clock edge.
- Single clock domain. Synchronous, active-high reset.

Parameters:
- LANE_W, default 1: width in bits of each input lane and of the output. Legal range is 1 to 32.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-high.
- in_data  input  8*LANE_W  eight packed lanes; lane i occupies bits [i*LANE_W +: LANE_W]; lane 0 is the LSBs.
- sel  input  3  lane select, 0 to 7.
- out  output  LANE_W  registered selected lane.

Behaviour:
- Interface: one clock; reset is synchronous and active-high (clk, rst).
- Reset: on a rising clk with rst=1, out is 0. Reset has priority over all other inputs. rst asserted mid-stream clears out at that edge, regardless of sel or in_data.
- Normal operation: at each rising clk with rst=0, out <= in_data[sel*LANE_W +: LANE_W].
- Latency: exactly 1 cycle from a sel or in_data change to the out update. No combinational path from inputs to out.
- Full select range: all 8 sel codes are valid; there is no out-of-range case. Code 7 selects the MSB lane.
- Simultaneous change of sel and in_data in the same cycle: out reflects the new sel applied to the new in_data at the next edge.
- Lanes that are not selected have no effect on out.
- X on sel must not be masked: X propagates to out (simulation only).
- Purely structural selection with no arithmetic. The output width equals LANE_W with no truncation or extension.

Optional Feature:
- Macro: MUX8_1_HOLD_EN.
- Defined:
  - Adds input port en (1 bit), placed after rst.
  - out updates only on edges where en=1; when en=0, out holds its previous value.
  - rst still clears out regardless of en.
- Undefined:
  - Port en does not exist.
  - out updates every cycle as described above.

Decomposition:
- Shared package mux8_1_pkg:
  - localparam N_LANES = 8.
  - localparam SEL_W = 3.
  - typedef sel_t, a logic vector of SEL_W bits.
- Natural sub-module: mux8_1_sel_comb. It is the purely combinational 8:1 lane select, parameterized by LANE_W.
- The top level, mux8_1, adds the output register, reset and the optional hold enable.

Test Plan:
- Reset: drive in_data=8'hFF, sel=3, rst=1 for 2 cycles -> out=0 on both edges. Release rst -> out=1 one cycle later.
- Lane walk (LANE_W=1): in_data=0, then for sel=0..7 set bit[sel]=0, wait one clock, set bit[sel]=1, wait one clock -> out=0 then out=1, each 1 cycle after the bit change.
- Isolation: sel=5, in_data=8'b1101_1111 -> out=0. Toggle every bit except bit 5 -> out stays 0.
- Mid-operation reset: sel=2, in_data=8'h04, out=1. Assert rst for one cycle -> out=0 at that edge. Deassert -> out=1 at the next edge.
- Wide lanes (LANE_W=8): in_data=64'h0706_0504_0302_0100, sweep sel 0..7 -> out=sel, with 1-cycle latency.
- MUX8_1_HOLD_EN: sel=1, in_data=8'h02, en=1 -> out=1. Set en=0, then in_data=0 -> out holds 1. Set en=1 -> out=0 next edge.

Source files
------------

// File: rtl/mux8_1_pkg.sv
// mux8_1 shared constants and types.
// Used by the lane selector, its bus interface and the registered top.
package mux8_1_pkg;

    localparam int N_LANES = 8;
    localparam int SEL_W   = 3;

    typedef logic [SEL_W-1:0] sel_t;

endpackage

// File: rtl/mux8_1_if.sv
// Lane bus for mux8_1: packed input lanes, select and registered output.
// The master drives lanes and select; the slave returns the chosen lane.
interface mux8_1_if
    import mux8_1_pkg::*;
#(
    parameter int LANE_W = 1
);

    logic [N_LANES*LANE_W-1:0] in_data;
    sel_t                      sel;
    logic [LANE_W-1:0]         out;

    modport master (
        output in_data,
        output sel,
        input  out
    );

    modport slave (
        input  in_data,
        input  sel,
        output out
    );

endinterface

// File: rtl/mux8_1_sel_comb.sv
// Combinational 8:1 lane select; lane i lives at [i*LANE_W +: LANE_W].
// An unknown select yields an unknown lane in simulation.
module mux8_1_sel_comb
    import mux8_1_pkg::*;
#(
    parameter int LANE_W = 1
) (
    input  logic [N_LANES*LANE_W-1:0] in_data,
    input  sel_t                      sel,
    output logic [LANE_W-1:0]         lane
);

    assign lane = in_data[sel*LANE_W +: LANE_W];

endmodule

// File: rtl/mux8_1.sv
// Registered 8-to-1 lane multiplexer with synchronous active-high reset.
// Define MUX8_1_HOLD_EN to add an en port that gates output updates.
module mux8_1
    import mux8_1_pkg::*;
#(
    parameter int LANE_W = 1
) (
    input  logic      clk,
    input  logic      rst,
`ifdef MUX8_1_HOLD_EN
    input  logic      en,
`endif
    mux8_1_if.slave   bus
);

    logic [LANE_W-1:0] lane;
    logic [LANE_W-1:0] q;
    logic              upd;

    mux8_1_sel_comb #(
        .LANE_W (LANE_W)
    ) u_sel (
        .in_data (bus.in_data),
        .sel     (bus.sel),
        .lane    (lane)
    );

`ifdef MUX8_1_HOLD_EN
    assign upd = en;
`else
    assign upd = 1'b1;
`endif

    // reset wins over the hold enable
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (upd) begin
            q <= lane;
        end
    end

    assign bus.out = q;

endmodule

// File: tb/tb_mux8_1.sv
// Scoreboard bench for mux8_1 with one 1-bit-lane and one 8-bit-lane instance.
// Covers MUX8_1_HOLD_EN when the macro is defined.
module tb_mux8_1;

    typedef struct {
        logic       e1;
        logic [7:0] e8;
        string      tag;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
`ifdef MUX8_1_HOLD_EN
    logic en  = 1'b1;
`endif

    mux8_1_if #(.LANE_W(1)) bus1 ();
    mux8_1_if #(.LANE_W(8)) bus8 ();

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    bit   stim_done = 1'b0;

    mux8_1 #(.LANE_W(1)) dut1 (
        .clk (clk),
        .rst (rst),
`ifdef MUX8_1_HOLD_EN
        .en  (en),
`endif
        .bus (bus1.slave)
    );

    mux8_1 #(.LANE_W(8)) dut8 (
        .clk (clk),
        .rst (rst),
`ifdef MUX8_1_HOLD_EN
        .en  (en),
`endif
        .bus (bus8.slave)
    );

    always #5 clk = ~clk;

    // drive one cycle of stimulus and queue the values expected after the edge
    task automatic step(
        input logic       r,
        input logic [7:0] i1,
        input logic [2:0] s1,
        input logic       e1,
        input logic [2:0] s8,
        input logic [7:0] e8,
        input string      tag
    );
        exp_t x;
        rst          = r;
        bus1.in_data = i1;
        bus1.sel     = s1;
        bus8.sel     = s8;
        x.e1  = e1;
        x.e8  = e8;
        x.tag = tag;
        sb.push_back(x);
        @(posedge clk);
        #2;
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                x = sb.pop_front();
                checks++;
                if (bus1.out !== x.e1) begin
                    failures++;
                    $display("FAIL %s lane1: got %b want %b",
                             x.tag, bus1.out, x.e1);
                end
                checks++;
                if (bus8.out !== x.e8) begin
                    failures++;
                    $display("FAIL %s lane8: got %h want %h",
                             x.tag, bus8.out, x.e8);
                end
            end
        end
    end

    initial begin : stim
        bus1.in_data = '0;
        bus1.sel     = '0;
        bus8.in_data = 64'h0706_0504_0302_0100;
        bus8.sel     = '0;
        @(negedge clk);

        step(1'b1, 8'hFF, 3'd3, 1'b0, 3'd4, 8'h00, "reset0");
        step(1'b1, 8'hFF, 3'd3, 1'b0, 3'd4, 8'h00, "reset1");
        step(1'b0, 8'hFF, 3'd3, 1'b1, 3'd4, 8'h04, "reset_rel");

        for (int s = 0; s < 8; s++) begin
            step(1'b0, 8'h00, 3'(s), 1'b0, 3'd0, 8'h00, "walk_lo");
            step(1'b0, 8'(1 << s), 3'(s), 1'b1, 3'd0, 8'h00, "walk_hi");
        end

        step(1'b0, 8'hDF, 3'd5, 1'b0, 3'd1, 8'h01, "iso_df");
        step(1'b0, 8'h00, 3'd5, 1'b0, 3'd1, 8'h01, "iso_00");
        step(1'b0, 8'h5A, 3'd5, 1'b0, 3'd1, 8'h01, "iso_5a");
        step(1'b0, 8'h20, 3'd5, 1'b1, 3'd1, 8'h01, "iso_20");

        step(1'b0, 8'h04, 3'd2, 1'b1, 3'd6, 8'h06, "mid_pre");
        step(1'b1, 8'h04, 3'd2, 1'b0, 3'd6, 8'h00, "mid_rst");
        step(1'b0, 8'h04, 3'd2, 1'b1, 3'd6, 8'h06, "mid_rel");

        for (int s = 0; s < 8; s++) begin
            step(1'b0, 8'h01, 3'd0, 1'b1, 3'(s), 8'(s), "wide");
        end

        step(1'b0, 8'h80, 3'd7, 1'b1, 3'd7, 8'h07, "msb_lane");
        step(1'b0, 8'h7F, 3'd7, 1'b0, 3'd7, 8'h07, "msb_clr");
        step(1'b0, 8'h40, 3'd6, 1'b1, 3'd2, 8'h02, "both_chg");

`ifdef MUX8_1_HOLD_EN
        en = 1'b1;
        step(1'b0, 8'h02, 3'd1, 1'b1, 3'd3, 8'h03, "hold_load");
        en = 1'b0;
        step(1'b0, 8'h02, 3'd1, 1'b1, 3'd5, 8'h03, "hold_en0");
        step(1'b0, 8'h00, 3'd1, 1'b1, 3'd5, 8'h03, "hold_data");
        en = 1'b1;
        step(1'b0, 8'h00, 3'd1, 1'b0, 3'd5, 8'h05, "hold_resume");
        step(1'b0, 8'h02, 3'd1, 1'b1, 3'd5, 8'h05, "hold_reload");
        en = 1'b0;
        step(1'b1, 8'h02, 3'd1, 1'b0, 3'd5, 8'h00, "hold_rst");
        step(1'b0, 8'h02, 3'd1, 1'b0, 3'd5, 8'h00, "hold_after");
        en = 1'b1;
        step(1'b0, 8'h02, 3'd1, 1'b1, 3'd5, 8'h05, "hold_end");
`endif

        stim_done = 1'b1;
    end

    initial begin : finisher
        int budget;
        wait (stim_done);
        budget = 0;
        while (sb.size() > 0 && budget < 10) begin
            @(posedge clk);
            budget++;
        end
        #3;
        if (sb.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain: got %0d pending want 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

endmodule
